// File: rtl/coproc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coproc_pkg
// Purpose  : Shared types and constants for the determinant coprocessor
//            datapath (element width, matrix order, loader state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package coproc_pkg;

  localparam int ELEM_W = 8;
  localparam int MAT_N  = 4;
  localparam int MAT4_W = MAT_N * MAT_N * ELEM_W;

  typedef logic signed [ELEM_W-1:0] elem_t;

  // Loader states: filling the matrix, or presenting it downstream.
  typedef enum logic [0:0] {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Packed MSB position of row-major element k (element 0 sits at the top).
  function automatic int slot_msb(input int k);
    return MAT4_W - 1 - ELEM_W * k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat4_loader.sv
`default_nettype none
// ============================================================================
// Module   : mat4_loader
// Purpose  : Collects N*N signed elements from a valid/ready stream,
//            row-major, into one packed matrix and hands it to the
//            determinant stage. Malformed frames raise frame_err and are
//            dropped instead of being forwarded.
// Revision : 1.0 - initial release
// ============================================================================
module mat4_loader #(
  parameter int ELEM_W = coproc_pkg::ELEM_W,
  parameter int N      = coproc_pkg::MAT_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ELEM_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*N*ELEM_W-1:0]   out_matrix,
  output logic                    frame_err
);

  import coproc_pkg::*;

  localparam int               BEATS     = N * N;
  localparam int               OUT_W     = BEATS * ELEM_W;
  localparam int               CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]   matrix_q, matrix_d;
  logic               frame_err_q, frame_err_d;

  logic               accept;
  logic [BEATS-1:0]   slot_en;

  // Flush blocks intake so a beat offered during the abort cycle is not lost silently.
  assign in_ready   = (state_q == LOAD) && !flush;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == HOLD);
  assign out_matrix = matrix_q;
  assign frame_err  = frame_err_q;

  // One write enable per element slot, keyed on the current beat count.
  for (genvar k = 0; k < BEATS; k++) begin : g_slot
    assign slot_en[k] = accept && (count_q == CNT_W'(k));
  end

  // Next-state, beat counter and framing check.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    if (flush) begin
      state_d = LOAD;
      count_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (count_q == LAST_SLOT) begin
              count_d = '0;
              if (in_last) begin
                state_d = HOLD;
              end else begin
                frame_err_d = 1'b1;
              end
            end else if (in_last) begin
              frame_err_d = 1'b1;
              count_d     = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = LOAD;
            count_d = '0;
          end
        end
        default: begin
          state_d = LOAD;
          count_d = '0;
        end
      endcase
    end
  end

  // Element storage: each accepted beat lands bit-exact in its slot; the
  // register is never cleared on handoff, consumers gate on out_valid.
  always_comb begin
    matrix_d = matrix_q;
    for (int k = 0; k < BEATS; k++) begin
      if (slot_en[k]) begin
        matrix_d[OUT_W-1-ELEM_W*k -: ELEM_W] = in_data;
      end
    end
  end

  // State, counter, matrix and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      count_q     <= '0;
      matrix_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      matrix_q    <= matrix_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat4_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat4_loader
// Purpose  : Self-checking bench for mat4_loader. A frame-level reference
//            model predicts complete matrices and framing errors; a monitor
//            compares every output handoff against the predicted queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat4_loader;

  import coproc_pkg::*;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_matrix;
  logic         frame_err;

  mat4_loader dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_matrix (out_matrix),
    .frame_err  (frame_err)
  );

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   cur[$];
  logic [127:0] exp_q[$];
  int           exp_ferr  = 0;
  int           seen_ferr = 0;
  logic [7:0]   mat_buf[16];
  logic         rdy_mode  = 1'b0;
  logic         rdy_force = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Frame-level model: a frame is good only if in_last arrives on exactly beat 16.
  function automatic logic [127:0] pack_cur();
    logic [127:0] m = '0;
    foreach (cur[i]) m = {m[119:0], cur[i]};
    return m;
  endfunction

  task automatic model_beat(input logic [7:0] d, input logic l);
    cur.push_back(d);
    if (l) begin
      if (cur.size() == 16) exp_q.push_back(pack_cur());
      else exp_ferr++;
      cur.delete();
    end else if (cur.size() == 16) begin
      exp_ferr++;
      cur.delete();
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; wait (bounded) for acceptance, then record it in the model.
  task automatic send_beat(input logic [7:0] d, input logic l);
    logic got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: actual=0 required=1");
    end else begin
      model_beat(d, l);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_seq(input int len, input logic last_end, input int gap_max);
    for (int i = 0; i < len; i++) begin
      int g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) sync();
      send_beat(mat_buf[i], last_end && (i == len - 1));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mat_buf[i] = 8'($urandom);
  endtask

  // Sole driver of out_ready: fixed level or random stalls.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Monitor: scoreboard pops on each handoff; HOLD must stay frozen.
  initial begin
    logic         prev_valid = 1'b0;
    logic         prev_hs    = 1'b0;
    logic [127:0] prev_mat   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (frame_err) seen_ferr++;
        if (out_valid && prev_valid && !prev_hs) begin
          chk("hold_matrix_stable", out_matrix, prev_mat);
          chk("hold_in_ready_low", {127'd0, in_ready}, 128'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_unexpected: actual=%h required=none", out_matrix);
          end else begin
            chk("scoreboard", out_matrix, exp_q.pop_front());
          end
        end
        prev_valid = out_valid;
        prev_hs    = out_valid && out_ready;
        prev_mat   = out_matrix;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_frame_err", {127'd0, frame_err}, 128'd0);
    chk("reset_out_matrix", out_matrix, 128'd0);
    rdy_force = 1'b1;
    sync();
    sync();

    // Elements 1..16 with consumer always ready.
    for (int i = 0; i < 16; i++) mat_buf[i] = 8'(i + 1);
    send_seq(16, 1'b1, 0);
    @(negedge clk);
    chk("t1_out_valid_rise", {127'd0, out_valid}, 128'd1);
    chk("t1_top_elem", {120'd0, out_matrix[127:120]}, 128'h01);
    chk("t1_last_elem", {120'd0, out_matrix[7:0]}, 128'h10);
    @(negedge clk);
    chk("t1_out_valid_drop", {127'd0, out_valid}, 128'd0);
    sync();

    // Identity matrix held for 10 stalled cycles.
    rdy_force = 1'b0;
    sync();
    for (int i = 0; i < 16; i++) mat_buf[i] = (i % 5 == 0) ? 8'h01 : 8'h00;
    send_seq(16, 1'b1, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t2_hold_valid", {127'd0, out_valid}, 128'd1);
      chk("t2_hold_matrix", out_matrix, 128'h01000000_00010000_00000100_00000001);
    end
    rdy_force = 1'b1;
    @(negedge clk);
    chk("t2_handshake_valid", {127'd0, out_valid}, 128'd1);
    chk("t2_handshake_in_ready", {127'd0, in_ready}, 128'd0);
    @(negedge clk);
    chk("t2_after_valid", {127'd0, out_valid}, 128'd0);
    chk("t2_after_in_ready", {127'd0, in_ready}, 128'd1);
    sync();

    // Early in_last on beat 5, then a clean matrix.
    fill_random();
    send_seq(5, 1'b1, 0);
    @(negedge clk);
    chk("t3_frame_err_pulse", {127'd0, frame_err}, 128'd1);
    chk("t3_no_out_valid", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    chk("t3_frame_err_clear", {127'd0, frame_err}, 128'd0);
    sync();
    fill_random();
    send_seq(16, 1'b1, 0);
    @(negedge clk);
    chk("t3_recovered_valid", {127'd0, out_valid}, 128'd1);
    sync();
    sync();

    // Sixteen beats with no in_last.
    fill_random();
    send_seq(16, 1'b0, 0);
    @(negedge clk);
    chk("t4_frame_err_pulse", {127'd0, frame_err}, 128'd1);
    chk("t4_no_out_valid", {127'd0, out_valid}, 128'd0);
    sync();

    // Asynchronous reset after beat 9.
    fill_random();
    send_seq(9, 1'b0, 0);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("t5_rst_out_matrix", out_matrix, 128'd0);
    cur.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Flush while a matrix is held.
    rdy_force = 1'b0;
    sync();
    fill_random();
    send_seq(16, 1'b1, 0);
    @(negedge clk);
    chk("t5_hold_valid", {127'd0, out_valid}, 128'd1);
    sync();
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_in_ready", {127'd0, in_ready}, 128'd0);
    sync();
    flush = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    cur.delete();
    @(negedge clk);
    chk("t5_flush_out_valid", {127'd0, out_valid}, 128'd0);
    chk("t5_flush_in_ready_back", {127'd0, in_ready}, 128'd1);
    rdy_force = 1'b1;
    sync();
    for (int i = 0; i < 16; i++) mat_buf[i] = 8'h80;
    send_seq(16, 1'b1, 0);
    @(negedge clk);
    chk("t5_m128_valid", {127'd0, out_valid}, 128'd1);
    for (int k = 0; k < 16; k++) begin
      chk("t5_m128_slot", {120'd0, out_matrix[slot_msb(k) -: 8]}, 128'h80);
    end
    sync();

    // Randomised traffic with stalls, gaps and occasional bad frames.
    rdy_mode = 1'b1;
    for (int m = 0; m < 100; m++) begin
      fill_random();
      if ($urandom_range(0, 9) == 0) send_seq($urandom_range(1, 15), 1'b1, 2);
      else send_seq(16, 1'b1, 3);
    end
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_scoreboard", 128'(exp_q.size()), 128'd0);
    repeat (2) @(negedge clk);
    chk("frame_err_count", 128'(seen_ferr), 128'(exp_ferr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
